// File: rtl/cmd_resp_deserializer_pkg.sv
// Shared SD CMD-line definitions: FSM states, frame lengths and CRC7 constants.
// Used by the response deserializer and the CRC7 engine.
package sd_cmd_defs;
    typedef enum logic [1:0] {IDLE, WAIT, RECV} state_t;

    localparam int SHORT_LEN = 48;
    localparam int LONG_LEN = 136;
    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam int LONG_CRC_MSB = 127;
endpackage

// File: rtl/cmd_resp_deserializer_if.sv
// Handshake/data bundle between the CMD pad sampler / command FSM and the
// response deserializer. master = controller side, slave = deserializer.
interface cmd_resp_deserializer_if;
    logic         in;
    logic         start;
    logic         long_resp;
    logic         crc_chk;
    logic [135:0] out;
    logic         valid;
    logic         crc_err;
    logic         frame_err;
    logic         timeout;
    logic         busy;

    modport master (output in, start, long_resp, crc_chk,
                    input  out, valid, crc_err, frame_err, timeout, busy);
    modport slave  (input  in, start, long_resp, crc_chk,
                    output out, valid, crc_err, frame_err, timeout, busy);
endinterface

// File: rtl/cmd_resp_deserializer_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first, zero initial value. Shared with the
// command serializer.
module sd_crc7
    import sd_cmd_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);
    logic fb;
    assign fb = bit_in ^ crc[6];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (en)
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
endmodule

// File: rtl/cmd_resp_deserializer.sv
// SD CMD response deserializer: waits for a start bit, shifts in a 48/136-bit
// frame and flags framing/CRC/timeout. CRC checking built only with CMD_CRC7_CHECK_EN.
module cmd_resp_deserializer
    import sd_cmd_defs::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input logic                    clk,
    input logic                    reset,
    cmd_resp_deserializer_if.slave bus
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state;
    logic                long_q;
    logic [CNT_W-1:0]    timer;
    logic [CNT_W-1:0]    bit_idx;
    logic [LONG_LEN-2:0] sreg;
    logic [LONG_LEN-1:0] frame;
    logic                trans_bit;
    logic                crc_bad;

    // Full frame as it will look once the current sample is shifted in.
    assign frame     = {sreg, bus.in};
    assign trans_bit = long_q ? frame[LONG_LEN-2] : frame[SHORT_LEN-2];

`ifdef CMD_CRC7_CHECK_EN
    logic       chk_q;
    logic       crc_clear;
    logic       crc_en;
    logic [6:0] crc;

    // Short frames include the start bit in the CRC; long frames skip 135..128.
    assign crc_clear = (state == IDLE) && bus.start;
    assign crc_en    = ((state == WAIT) && !bus.in && !long_q) ||
                       ((state == RECV) && (bit_idx >= CNT_W'(8)) &&
                        (bit_idx <= CNT_W'(LONG_CRC_MSB)));
    assign crc_bad   = chk_q && (crc != frame[7:1]);

    sd_crc7 u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (crc_clear),
        .en     (crc_en),
        .bit_in (bus.in),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            chk_q <= 1'b0;
        else if (crc_clear)
            chk_q <= bus.crc_chk;
    end
`else
    logic unused_crc_chk;
    assign unused_crc_chk = bus.crc_chk;
    assign crc_bad        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            long_q        <= 1'b0;
            timer         <= '0;
            bit_idx       <= '0;
            sreg          <= '0;
            bus.out       <= '0;
            bus.valid     <= 1'b0;
            bus.crc_err   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.valid   <= 1'b0;
            bus.timeout <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state    <= WAIT;
                    bus.busy <= 1'b1;
                    long_q   <= bus.long_resp;
                    timer    <= '0;
                    sreg     <= '0;
                end
                WAIT: begin
                    // Start bit is 0, already the register's contents, so no shift here.
                    if (!bus.in) begin
                        state   <= RECV;
                        bit_idx <= long_q ? CNT_W'(LONG_LEN - 2) : CNT_W'(SHORT_LEN - 2);
                    end else if (timer == TMO_LAST) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.timeout <= 1'b1;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                RECV: begin
                    sreg <= {sreg[LONG_LEN-3:0], bus.in};
                    if (bit_idx == '0) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.valid     <= 1'b1;
                        bus.out       <= frame;
                        bus.crc_err   <= crc_bad;
                        bus.frame_err <= trans_bit | ~bus.in;
                    end else begin
                        bit_idx <= bit_idx - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_resp_deserializer.sv
// Randomised self-checking bench for cmd_resp_deserializer against a
// frame-level reference model (long-division CRC7, framing rules).
module tb_cmd_resp_deserializer;
`ifdef CMD_CRC7_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    int           v_at;
    int           v_cnt;
    logic [135:0] s_out;
    logic         s_crc;
    logic         s_fe;

    cmd_resp_deserializer_if bus();

    cmd_resp_deserializer #(.TIMEOUT(64), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remainder of data(x)*x^7 divided by x^7+x^3+1, n message bits.
    function automatic logic [6:0] crc7_div(input logic [127:0] data, input int n);
        logic [134:0] m;
        m = {data, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    function automatic logic [6:0] ref_crc(input logic [135:0] f, input bit lng);
        logic [127:0] d;
        if (lng) d = {8'b0, f[127:8]};
        else     d = {88'b0, f[47:8]};
        return crc7_div(d, lng ? 120 : 40);
    endfunction

    function automatic logic exp_crc_err(input logic [135:0] f, input bit lng, input bit chk);
        return CRC_ON && chk && (ref_crc(f, lng) != f[7:1]);
    endfunction

    function automatic logic exp_frame_err(input logic [135:0] f, input bit lng);
        return (lng ? f[134] : f[46]) | ~f[0];
    endfunction

    function automatic logic [135:0] exp_out(input logic [135:0] f, input bit lng);
        return lng ? f : {88'b0, f[47:0]};
    endfunction

    task automatic build_frame(output logic [135:0] f, input bit lng, input bit good,
                               input bit trans, input bit endb);
        logic [6:0] c;
        f = '0;
        for (int w = 0; w < 5; w++) f[w*32 +: 32] = $urandom;
        f[135:136-8] = f[135:128];
        if (lng) begin
            f[135] = 1'b0; f[134] = trans; f[133:128] = 6'h3F;
        end else begin
            f[135:48] = '0; f[47] = 1'b0; f[46] = trans;
        end
        c = ref_crc(f, lng);
        if (!good) c = c ^ 7'($urandom_range(1, 127));
        f[7:1] = c;
        f[0] = endb;
    endtask

    // Arms, idles high, then shifts the frame MSB-first; records the valid pulse.
    task automatic drive_frame(input logic [135:0] f, input bit lng, input bit chk,
                               input int idle, input bit poke);
        int len;
        len = lng ? 136 : 48;
        v_at = -1; v_cnt = 0;
        bus.start = 1'b1; bus.long_resp = lng; bus.crc_chk = chk; bus.in = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < idle; k++) begin
            if (poke && k == 0) begin
                bus.start = 1'b1; bus.long_resp = ~lng; bus.crc_chk = ~chk;
            end
            tick();
            bus.start = 1'b0; bus.long_resp = lng; bus.crc_chk = chk;
        end
        for (int i = len - 1; i >= 0; i--) begin
            bus.in = f[i];
            tick();
            if (bus.valid) begin
                v_cnt++; v_at = i;
                s_out = bus.out; s_crc = bus.crc_err; s_fe = bus.frame_err;
            end
        end
        bus.in = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in = 1'b1; bus.start = 1'b0; bus.long_resp = 1'b0; bus.crc_chk = 1'b0;
        tick(); tick();
        total++; if (bus.out !== 136'b0) begin bad++; $display("FAIL reset_out got=%h exp=0", bus.out); end
        total++; if ({bus.valid, bus.crc_err, bus.frame_err, bus.timeout, bus.busy} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000",
                            {bus.valid, bus.crc_err, bus.frame_err, bus.timeout, bus.busy});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_short_directed();
        logic [135:0] f;
        logic [7:0] tails [3] = '{8'h13, 8'h15, 8'h12};
        for (int t = 0; t < 3; t++) begin
            f = {88'b0, 40'h08000001AA, tails[t]};
            drive_frame(f, 1'b0, 1'b1, 3, 1'b0);
            total++; if (v_cnt != 1 || v_at != 0) begin
                bad++; $display("FAIL short%0d_valid got cnt=%0d at_bit=%0d exp cnt=1 at_bit=0", t, v_cnt, v_at);
            end
            total++; if (s_out !== exp_out(f, 1'b0)) begin bad++; $display("FAIL short%0d_out got=%h exp=%h", t, s_out, f); end
            total++; if (s_crc !== exp_crc_err(f, 1'b0, 1'b1)) begin
                bad++; $display("FAIL short%0d_crc got=%b exp=%b", t, s_crc, exp_crc_err(f, 1'b0, 1'b1));
            end
            total++; if (s_fe !== exp_frame_err(f, 1'b0)) begin
                bad++; $display("FAIL short%0d_frame got=%b exp=%b", t, s_fe, exp_frame_err(f, 1'b0));
            end
            tick();
            total++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
                bad++; $display("FAIL short%0d_after got valid=%b busy=%b exp 0 0", t, bus.valid, bus.busy);
            end
        end
    endtask

    task automatic test_timeout();
        int pulses, at, vseen;
        pulses = 0; at = -1; vseen = 0;
        bus.start = 1'b1; bus.long_resp = 1'b0; bus.crc_chk = 1'b1; bus.in = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL tmo_busy_rise got=%b exp=1", bus.busy); end
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (bus.timeout) begin pulses++; at = k; end
            if (bus.valid) vseen++;
        end
        total++; if (pulses != 1 || at != 64) begin
            bad++; $display("FAIL tmo_pulse got cnt=%0d at=%0d exp cnt=1 at=64", pulses, at);
        end
        total++; if (vseen != 0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL tmo_idle got valids=%0d busy=%b exp 0 0", vseen, bus.busy);
        end
    endtask

    task automatic test_long();
        logic [135:0] f;
        for (int t = 0; t < 3; t++) begin
            build_frame(f, 1'b1, 1'b1, 1'b0, 1'b1);
            drive_frame(f, 1'b1, 1'b1, $urandom_range(0, 10), 1'b0);
            total++; if (v_cnt != 1 || v_at != 0) begin
                bad++; $display("FAIL long%0d_valid got cnt=%0d at_bit=%0d exp cnt=1 at_bit=0", t, v_cnt, v_at);
            end
            total++; if (s_out !== f || s_crc !== 1'b0 || s_fe !== 1'b0) begin
                bad++; $display("FAIL long%0d_data got=%h crc=%b fe=%b exp=%h 0 0", t, s_out, s_crc, s_fe, f);
            end
        end
    endtask

    task automatic test_random();
        logic [135:0] f;
        bit lng, chk, good, tr, eb;
        int idle;
        for (int t = 0; t < 24; t++) begin
            lng = 1'($urandom); chk = 1'($urandom);
            good = ($urandom_range(0, 3) != 0); tr = ($urandom_range(0, 5) == 0);
            eb = ($urandom_range(0, 5) != 0);
            idle = (t == 0) ? 63 : (t == 1) ? 0 : $urandom_range(0, 63);
            build_frame(f, lng, good, tr, eb);
            drive_frame(f, lng, chk, idle, 1'b0);
            total++; if (v_cnt != 1 || v_at != 0 || s_out !== exp_out(f, lng) ||
                         s_crc !== exp_crc_err(f, lng, chk) || s_fe !== exp_frame_err(f, lng)) begin
                bad++; $display("FAIL rand%0d got cnt=%0d at=%0d out=%h crc=%b fe=%b exp out=%h crc=%b fe=%b",
                                t, v_cnt, v_at, s_out, s_crc, s_fe, exp_out(f, lng),
                                exp_crc_err(f, lng, chk), exp_frame_err(f, lng));
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [135:0] f;
        build_frame(f, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_frame(f, 1'b0, 1'b1, 4, 1'b1);
        total++; if (v_cnt != 1 || v_at != 0 || s_out !== exp_out(f, 1'b0) ||
                     s_crc !== exp_crc_err(f, 1'b0, 1'b1)) begin
            bad++; $display("FAIL start_busy got cnt=%0d at=%0d out=%h crc=%b exp out=%h crc=%b",
                            v_cnt, v_at, s_out, s_crc, exp_out(f, 1'b0), exp_crc_err(f, 1'b0, 1'b1));
        end
    endtask

    task automatic test_hold_and_back_to_back();
        logic [135:0] f, g;
        build_frame(f, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_frame(f, 1'b0, 1'b1, 2, 1'b0);
        // Next arm lands in the valid cycle.
        build_frame(g, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_frame(g, 1'b1, 1'b0, 1, 1'b0);
        total++; if (v_cnt != 1 || v_at != 0 || s_out !== g || s_fe !== 1'b1 || s_crc !== 1'b0) begin
            bad++; $display("FAIL b2b got cnt=%0d at=%0d out=%h fe=%b crc=%b exp out=%h fe=1 crc=0",
                            v_cnt, v_at, s_out, s_fe, s_crc, g);
        end
        // Arm during valid, let it time out: result registers must hold.
        bus.start = 1'b1; bus.long_resp = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 66; k++) tick();
        total++; if (bus.out !== g || bus.frame_err !== 1'b1 || bus.crc_err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL hold got out=%h fe=%b crc=%b busy=%b exp out=%h 1 0 0",
                            bus.out, bus.frame_err, bus.crc_err, bus.busy, g);
        end
    endtask

    task automatic test_reset_mid();
        logic [135:0] f;
        build_frame(f, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_frame(f, 1'b0, 1'b1, 1, 1'b0);
        build_frame(f, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.start = 1'b1; bus.long_resp = 1'b0; bus.crc_chk = 1'b1; bus.in = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        for (int i = 47; i > 20; i--) begin bus.in = f[i]; tick(); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
        reset = 1'b0;
        #1;
        total++; if (bus.out !== 136'b0 || {bus.valid, bus.crc_err, bus.frame_err, bus.timeout, bus.busy} !== 5'b0) begin
            bad++; $display("FAIL mid_reset got out=%h flags=%b exp 0", bus.out,
                            {bus.valid, bus.crc_err, bus.frame_err, bus.timeout, bus.busy});
        end
        bus.in = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        drive_frame(f, 1'b0, 1'b1, 2, 1'b0);
        total++; if (v_cnt != 1 || v_at != 0 || s_out !== exp_out(f, 1'b0) || s_crc !== 1'b0 || s_fe !== 1'b0) begin
            bad++; $display("FAIL mid_rearm got cnt=%0d at=%0d out=%h crc=%b fe=%b exp out=%h 0 0",
                            v_cnt, v_at, s_out, s_crc, s_fe, exp_out(f, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_short_directed();
        test_timeout();
        test_long();
        test_random();
        test_start_ignored();
        test_hold_and_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
